// File: rtl/fp_sqrt_seq_pkg.sv
// Shared FPU definitions for the FSQRT issue/response sequencer:
// rounding modes, fflags bit positions, sequencer states and rm helpers.
package fp_sqrt_seq_pkg;

    localparam int unsigned RM_W     = 3;
    localparam int unsigned FFLAGS_W = 5;

    localparam logic [RM_W-1:0] RM_RNE = 3'b000;
    localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
    localparam logic [RM_W-1:0] RM_RDN = 3'b010;
    localparam logic [RM_W-1:0] RM_RUP = 3'b011;
    localparam logic [RM_W-1:0] RM_RMM = 3'b100;
    localparam logic [RM_W-1:0] RM_DYN = 3'b111;

    localparam int unsigned FFLAG_NX = 0;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_NV = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Dynamic rm in the instruction defers to fcsr.frm.
    function automatic logic [RM_W-1:0] resolve_rm(input logic [RM_W-1:0] rm,
                                                   input logic [RM_W-1:0] frm);
        return (rm == RM_DYN) ? frm : rm;
    endfunction

    function automatic logic rm_is_legal(input logic [RM_W-1:0] rm);
        logic ok;
        case (rm)
            RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Square root can only raise invalid or inexact.
    function automatic logic [FFLAGS_W-1:0] sqrt_fflags(input logic nv, input logic nx);
        logic [FFLAGS_W-1:0] f;
        f           = '0;
        f[FFLAG_NV] = nv;
        f[FFLAG_DZ] = 1'b0;
        f[FFLAG_OF] = 1'b0;
        f[FFLAG_UF] = 1'b0;
        f[FFLAG_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/fp_sqrt_seq.sv
// Issue/response sequencer between FPU issue and the multi-cycle sqrt unit.
// Optional watchdog on the unit enabled by FP_SQRT_SEQ_TIMEOUT_EN.
module fp_sqrt_seq
    import fp_sqrt_seq_pkg::*;
#(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned TAG_W = 5
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 128
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [RM_W-1:0]     frm,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FLEN-1:0]     req_operand,
    input  logic [RM_W-1:0]     req_rm,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                sq_start,
    output logic [FLEN-1:0]     sq_operand,
    output logic [RM_W-1:0]     sq_rm,
    input  logic                sq_done,
    input  logic [FLEN-1:0]     sq_result,
    input  logic                sq_nv,
    input  logic                sq_nx,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [FLEN-1:0]     rsp_result,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [FFLAGS_W-1:0] rsp_fflags,
    output logic                rsp_illegal,
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
    output logic                rsp_timeout,
`endif
    output logic                busy
);

    state_e          state;
    logic [RM_W-1:0] eff_rm;
    logic            eff_legal;

    assign eff_rm    = resolve_rm(req_rm, frm);
    assign eff_legal = rm_is_legal(eff_rm);

    assign req_ready = (state == ST_IDLE) && !flush;
    assign sq_start  = (state == ST_ISSUE);

`ifdef FP_SQRT_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Operand and rm registers only change on accept, so they stay stable until sq_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sq_operand  <= '0;
            sq_rm       <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_tag     <= '0;
            rsp_fflags  <= '0;
            rsp_illegal <= 1'b0;
            busy        <= 1'b0;
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        sq_operand <= req_operand;
                        sq_rm      <= eff_rm;
                        rsp_tag    <= req_tag;
                        busy       <= 1'b1;
                        if (eff_legal) begin
                            state <= ST_ISSUE;
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_illegal <= 1'b1;
                            rsp_result  <= '0;
                            rsp_fflags  <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= flush ? ST_DRAIN : ST_WAIT;
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
                    wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    if (sq_done) begin
                        if (flush) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state      <= ST_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= sq_result;
                            rsp_fflags <= sqrt_fflags(sq_nv, sq_nx);
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= '0;
                        rsp_fflags  <= '0;
                        rsp_timeout <= 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    // A flush coinciding with the handshake just completes it.
                    if (flush || rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_illegal <= 1'b0;
                        busy        <= 1'b0;
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                    end
                end
                ST_DRAIN: begin
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (sq_done || timed_out) begin
`else
                    if (sq_done) begin
`endif
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Self-checking bench for fp_sqrt_seq: transaction-level model plus a per-cycle
// compare process; covers timeout behaviour when FP_SQRT_SEQ_TIMEOUT_EN is defined.
module tb_fp_sqrt_seq;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, sq_start, sq_done, sq_nv, sq_nx;
    logic        rsp_valid, rsp_ready, rsp_illegal, busy;
    logic [2:0]  frm, req_rm, sq_rm;
    logic [31:0] req_operand, sq_operand, sq_result, rsp_result;
    logic [4:0]  req_tag, rsp_tag, rsp_fflags;
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
    logic        rsp_timeout;
    logic        exp_to = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Transaction-level model state, updated by the driver just after each edge.
    bit          chk_en = 0, exp_idle = 1, start_exp = 0, unit_active = 0, rsp_exp_on = 0;
    logic [31:0] exp_sq_op = '0, exp_res = '0;
    logic [2:0]  exp_sq_rm = '0;
    logic [4:0]  exp_tag = '0, exp_ff = '0;
    logic        exp_ill = 1'b0;

    bit          lit_en = 0, lit_rm_en = 0;
    logic [31:0] lit_res = '0;
    logic [4:0]  lit_ff = '0;
    logic [2:0]  lit_rm = '0;

    fp_sqrt_seq #(.FLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .frm(frm),
        .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
        .req_rm(req_rm), .req_tag(req_tag),
        .sq_start(sq_start), .sq_operand(sq_operand), .sq_rm(sq_rm),
        .sq_done(sq_done), .sq_result(sq_result), .sq_nv(sq_nv), .sq_nx(sq_nx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
        .rsp_timeout(rsp_timeout),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    function automatic bit rm_legal(input logic [2:0] r);
        return r < 3'd5;
    endfunction

    function automatic logic [4:0] model_fflags(input logic nv, input logic nx);
        return {nv, 3'b000, nx};
    endfunction

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("req_ready", 64'(req_ready), 64'(exp_idle && !flush));
            check("busy", 64'(busy), 64'(!exp_idle));
            check("sq_start", 64'(sq_start), 64'(start_exp));
            check("rsp_valid", 64'(rsp_valid), 64'(rsp_exp_on));
            if (rsp_exp_on) begin
                check("rsp_result", 64'(rsp_result), 64'(exp_res));
                check("rsp_tag", 64'(rsp_tag), 64'(exp_tag));
                check("rsp_fflags", 64'(rsp_fflags), 64'(exp_ff));
                check("rsp_illegal", 64'(rsp_illegal), 64'(exp_ill));
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
                check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
`endif
            end
            if (unit_active) begin
                check("sq_operand_hold", 64'(sq_operand), 64'(exp_sq_op));
                check("sq_rm_hold", 64'(sq_rm), 64'(exp_sq_rm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rsp(input logic [31:0] res, input logic [4:0] tag, input logic [4:0] ff,
                           input logic ill);
        exp_res = res; exp_tag = tag; exp_ff = ff; exp_ill = ill;
`ifdef FP_SQRT_SEQ_TIMEOUT_EN
        exp_to = 1'b0;
`endif
        rsp_exp_on = 1;
    endtask

    // Holds the response for rdy_delay cycles (with noise on sq_done/req_valid), then retires it.
    task automatic finish_resp(input int rdy_delay, input bit resp_flush);
        if (lit_en) begin
            #2;
            check("lit_result", 64'(rsp_result), 64'(lit_res));
            check("lit_fflags", 64'(rsp_fflags), 64'(lit_ff));
            lit_en = 0;
        end
        for (int i = 0; i < rdy_delay; i++) begin
            sq_done   = 1'($urandom_range(0, 1));
            req_valid = 1'($urandom_range(0, 1));
            tick();
        end
        sq_done = 1'b0; req_valid = 1'b0;
        if (resp_flush) begin
            flush     = 1'b1;
            rsp_ready = 1'($urandom_range(0, 1));
        end else begin
            rsp_ready = 1'b1;
        end
        tick();
        flush = 1'b0; rsp_ready = 1'b0;
        rsp_exp_on = 0; exp_idle = 1;
    endtask

    task automatic do_op(input logic [31:0] op, input logic [2:0] rm, input logic [2:0] frm_v,
                         input logic [4:0] tag, input int lat, input logic [31:0] res,
                         input logic nv, input logic nx, input int flush_k,
                         input int rdy_delay, input bit resp_flush);
        logic [2:0] eff;
        bit         flushed;
        eff = (rm == 3'b111) ? frm_v : rm;
        frm = frm_v; req_valid = 1'b1; req_operand = op; req_rm = rm; req_tag = tag;
        tick();
        req_valid = 1'b0; req_operand = $urandom; req_rm = 3'($urandom);
        req_tag = 5'($urandom); frm = 3'($urandom);
        exp_idle = 0;
        if (!rm_legal(eff)) begin
            set_rsp(32'h0, tag, 5'b0, 1'b1);
            finish_resp(rdy_delay, resp_flush);
            return;
        end
        start_exp = 1; unit_active = 1; exp_sq_op = op; exp_sq_rm = eff;
        if (lit_rm_en) begin
            #2;
            check("lit_sq_rm", 64'(sq_rm), 64'(lit_rm));
            lit_rm_en = 0;
        end
        flushed = (flush_k >= 0) && (flush_k <= lat);
        for (int k = 0; k <= lat; k++) begin
            flush     = (k == flush_k);
            req_valid = 1'($urandom_range(0, 1));
            if (k == lat) begin
                sq_done = 1'b1; sq_result = res; sq_nv = nv; sq_nx = nx;
            end
            tick();
            start_exp = 0; flush = 1'b0; sq_done = 1'b0;
            sq_result = $urandom; sq_nv = 1'($urandom); sq_nx = 1'($urandom);
        end
        req_valid = 1'b0; unit_active = 0;
        if (flushed) begin
            exp_idle = 1;
            return;
        end
        set_rsp(res, tag, model_fflags(nv, nx), 1'b0);
        finish_resp(rdy_delay, resp_flush);
    endtask

    initial begin
        int lat, fk;
        reset = 1'b1; flush = 1'b0; frm = '0; req_valid = 1'b0; req_operand = '0;
        req_rm = '0; req_tag = '0; sq_done = 1'b0; sq_result = '0; sq_nv = 1'b0;
        sq_nx = 1'b0; rsp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(1));
        check("reset_sq_start", 64'(sq_start), 64'(0));
        check("reset_sq_operand", 64'(sq_operand), 64'(0));
        chk_en = 1;
        tick();

        // Directed cases with literal expectations.
        lit_en = 1; lit_res = 32'h40000000; lit_ff = 5'b00000;
        do_op(32'h40800000, 3'b000, 3'b000, 5'd3, 3, 32'h40000000, 1'b0, 1'b0, -1, 0, 1'b0);
        lit_rm_en = 1; lit_rm = 3'b011; lit_en = 1; lit_res = 32'h3FB504F4; lit_ff = 5'b00001;
        do_op(32'h40000000, 3'b111, 3'b011, 5'd7, 4, 32'h3FB504F4, 1'b0, 1'b1, -1, 1, 1'b0);
        lit_en = 1; lit_res = 32'h0; lit_ff = 5'b00000;
        do_op(32'h12345678, 3'b101, 3'b000, 5'd9, 2, 32'h0, 1'b0, 1'b0, -1, 0, 1'b0);
        do_op(32'h12345678, 3'b111, 3'b110, 5'd10, 2, 32'h0, 1'b0, 1'b0, -1, 2, 1'b0);
        lit_en = 1; lit_res = 32'h7FC00000; lit_ff = 5'b10000;
        do_op(32'hBF800000, 3'b000, 3'b000, 5'd1, 2, 32'h7FC00000, 1'b1, 1'b0, -1, 5, 1'b0);
        do_op(32'h41100000, 3'b001, 3'b000, 5'd4, 5, 32'h40400000, 1'b0, 1'b0, 2, 0, 1'b0);
        do_op(32'h40400000, 3'b010, 3'b000, 5'd5, 2, 32'h3FDDB3D7, 1'b0, 1'b1, -1, 0, 1'b0);
        do_op(32'h40800000, 3'b100, 3'b000, 5'd6, 3, 32'h40000000, 1'b0, 1'b0, 0, 0, 1'b0);
        do_op(32'h40800000, 3'b000, 3'b000, 5'd8, 3, 32'h40000000, 1'b0, 1'b0, 3, 0, 1'b0);
        do_op(32'h41800000, 3'b000, 3'b000, 5'd11, 1, 32'h40800000, 1'b0, 1'b0, -1, 2, 1'b1);

        // Flush in IDLE blocks acceptance; stray sq_done in IDLE is ignored.
        req_valid = 1'b1; flush = 1'b1; sq_done = 1'b1; req_operand = 32'h40800000; req_rm = '0;
        tick();
        req_valid = 1'b0; flush = 1'b0; sq_done = 1'b0;
        tick();

        // Reset while waiting on the unit.
        frm = '0; req_valid = 1'b1; req_operand = 32'h40800000; req_rm = 3'b000; req_tag = 5'd12;
        tick();
        req_valid = 1'b0; exp_idle = 0; start_exp = 1; unit_active = 1;
        exp_sq_op = 32'h40800000; exp_sq_rm = 3'b000;
        tick();
        start_exp = 0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; exp_idle = 1; unit_active = 0;
        #2;
        check("rst_wait_busy", 64'(busy), 64'(0));
        check("rst_wait_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_wait_req_ready", 64'(req_ready), 64'(1));
        check("rst_wait_sq_operand", 64'(sq_operand), 64'(0));
        check("rst_wait_sq_rm", 64'(sq_rm), 64'(0));
        check("rst_wait_rsp_tag", 64'(rsp_tag), 64'(0));
        tick();

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            lat = int'($urandom_range(1, 8));
            fk  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32'(lat))) : -1;
            do_op($urandom, 3'($urandom), 3'($urandom), 5'($urandom), lat, $urandom,
                  1'($urandom), 1'($urandom), fk, int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef FP_SQRT_SEQ_TIMEOUT_EN
        // Withheld sq_done: response after 128 cycles in WAIT.
        frm = '0; req_valid = 1'b1; req_operand = 32'h40800000; req_rm = 3'b000; req_tag = 5'd20;
        tick();
        req_valid = 1'b0; exp_idle = 0; start_exp = 1; unit_active = 1;
        exp_sq_op = 32'h40800000; exp_sq_rm = 3'b000;
        tick();
        start_exp = 0;
        repeat (127) tick();
        tick();
        unit_active = 0;
        set_rsp(32'h0, 5'd20, 5'b0, 1'b0);
        exp_to = 1'b1;
        #2;
        check("lit_timeout", 64'(rsp_timeout), 64'(1));
        finish_resp(1, 1'b0);
        exp_to = 1'b0;
`endif

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_seq.md
# fp_sqrt_seq

Issue/response sequencer between the FPU issue stage and the multi-cycle square-root unit. It accepts one FSQRT request at a time over a valid/ready handshake and resolves the rounding mode. It drives the unit's start pulse and holds operand and rounding mode stable for the whole operation. It then returns result, tag and fflags to writeback over a second valid/ready handshake, and absorbs pipeline flushes by draining the unit, which cannot be aborted.

## Interface
- FLEN, 32: operand/result width (32 or 64).
- TAG_W, 5: destination tag width (rd index).
- TIMEOUT_CYCLES, 128: watchdog limit; used only with FP_SQRT_SEQ_TIMEOUT_EN.

- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill current request (pipeline redirect).
- frm  in  3  fcsr.frm, used when req_rm == 3'b111.
- req_valid / req_ready  in / out  1  request handshake.
- req_operand  in  FLEN  radicand.
- req_rm  in  3  instruction rm field.
- req_tag  in  TAG_W  destination tag.
- sq_start  out  1  one-cycle start pulse to sqrt unit.
- sq_operand  out  FLEN  held operand.
- sq_rm  out  3  held resolved rounding mode.
- sq_done  in  1  unit completion pulse; sq_result/sq_nv/sq_nx are valid in the same cycle.
- sq_result  in  FLEN; sq_nv, sq_nx  in  1.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_result  out  FLEN; rsp_tag  out  TAG_W.
- rsp_fflags  out  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF always 0.
- rsp_illegal  out  1  illegal rounding mode, no result written.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- req_ready = (state==IDLE) && !flush.
- rm resolution at accept:
  - eff_rm = (req_rm==3'b111) ? frm : req_rm.
  - eff_rm in {3'b101, 3'b110, 3'b111} is illegal.
- IDLE, accept:
  - Capture operand, eff_rm and tag.
  - Illegal rm: go to RESP with rsp_illegal=1, result 0, fflags 0. No unit launch.
  - Legal rm: go to ISSUE.
- ISSUE: sq_start=1 for exactly this cycle, then WAIT.
- WAIT: on sq_done, capture sq_result and fflags={sq_nv,0,0,0,sq_nx}, then go to RESP.
- RESP: rsp_valid=1. Outputs hold stable until rsp_valid&&rsp_ready, then go to IDLE.
- sq_operand and sq_rm stay constant from ISSUE through the sq_done cycle, because the unit re-reads both after start.
- Flush:
  - In ISSUE or WAIT: go to DRAIN. An sq_done in the same cycle also drops the result and goes to IDLE.
  - In DRAIN: wait for sq_done, discard the result, go to IDLE.
  - In RESP: drop the response and go to IDLE. If the rsp handshake occurs in the same cycle, it counts as completed; the only further effect of the flush is returning to IDLE.
  - In IDLE: no effect, and no acceptance that cycle.
- sq_done outside WAIT or DRAIN is ignored.
- Reset, including in mid-operation: every output goes to 0, state goes to IDLE. The unit is assumed to be reset by the same reset.

## Timing
- Accept in cycle T → sq_start at T+1 → sq_done at D → rsp_valid at D+1.
- Illegal rm: rsp_valid at T+1.
- No fixed unit latency is assumed.
- Earliest next accept is the cycle after the rsp handshake. rsp_ready held high gives one op per (D-T+2) cycles.
- All outputs are registered except req_ready and sq_start, which decode state.

## Configuration
- FP_SQRT_SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and DRAIN.
  - When it reaches TIMEOUT_CYCLES without sq_done: WAIT goes to RESP with fflags 0 and extra output rsp_timeout=1; DRAIN goes to IDLE.
  - The counter clears on state entry.
- Undefined: no counter and no rsp_timeout port. WAIT and DRAIN wait indefinitely.

## Structure
- Shared FPU package holds:
  - Rounding-mode encodings: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - fflags bit positions.
  - State encodings.
- Single module; no sub-module. Rm resolution is a small function in the package.

## Test plan
- Operand 0x40800000, rm=000, tag=3 → one sq_start pulse. The unit returns 0x40000000 with nv=0, nx=0 → rsp_result=0x40000000, rsp_tag=3, rsp_fflags=0.
- req_rm=111, frm=011, operand 0x40000000 → sq_rm=011 held until sq_done. Result 0x3FB504F4 → rsp_fflags=5'b00001.
- req_rm=101 → no sq_start, rsp_valid at T+1 with rsp_illegal=1 and result 0.
- Operand 0xBF800000 → unit returns 0x7FC00000 with nv=1 → rsp_fflags=5'b10000. rsp_ready held low for 5 cycles → outputs stable, req_ready=0 throughout.
- flush two cycles after sq_start → DRAIN. sq_done later produces no rsp_valid. The next request is accepted the cycle after the drop.
- reset asserted in WAIT → next cycle busy=0, rsp_valid=0, req_ready=1. With the timeout macro, withheld sq_done for 128 cycles → rsp_timeout=1.
